// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search controller driving an external comparator
// Optional feature macro: SAR_EARLY_EXIT_EN (stop on the first equal compare).
module sar_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_gt,
   input  logic             cmp_lt,
   input  logic             cmp_eq,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int KW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
   localparam logic [KW-1:0]    K_TOP = KW'(WIDTH - 1);
   localparam logic [KW-1:0]    K_ONE = KW'(1);

   typedef enum logic [1:0] {IDLE, TEST, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n, acc_new, guess_n, result_n;
   logic [KW-1:0]    k, k_n;
   logic             err_n, one_hot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         guess  <= '0;
         result <= '0;
         acc    <= '0;
         k      <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_n;
         guess  <= guess_n;
         result <= result_n;
         acc    <= acc_n;
         k      <= k_n;
         err    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      acc_n    = acc;
      guess_n  = guess;
      result_n = result;
      k_n      = k;
      err_n    = err;
      one_hot  = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100) ||
                 ({cmp_gt, cmp_lt, cmp_eq} == 3'b010) ||
                 ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);
      // Target at or above the trial value means the trial bit belongs in the answer.
      acc_new  = (cmp_gt || cmp_eq) ? guess : acc;
      case (state)
         IDLE: begin
            if (start) begin
               acc_n   = '0;
               k_n     = K_TOP;
               guess_n = ONE << K_TOP;
               err_n   = 1'b0;
               state_n = TEST;
            end
         end
         TEST: begin
            if (!one_hot) begin
               err_n    = 1'b1;
               result_n = '0;
               state_n  = DONE;
            end
`ifdef SAR_EARLY_EXIT_EN
            else if (cmp_eq) begin
               acc_n    = guess;
               result_n = guess;
               state_n  = DONE;
            end
`endif
            else if (k != '0) begin
               acc_n   = acc_new;
               k_n     = k - K_ONE;
               guess_n = acc_new | (ONE << (k - K_ONE));
            end else begin
               acc_n    = acc_new;
               result_n = acc_new;
               state_n  = DONE;
            end
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state == TEST);
   assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - directed vector bench for sar_search with a behavioural comparator
module tb_sar_search;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       cmp_gt, cmp_lt, cmp_eq;
   logic [3:0] guess, result;
   logic       busy, done, err;
   logic [3:0] target = 4'h0;
   logic       force_bad = 1'b0;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   // External comparator: target on a, guess on b; force_bad breaks one-hotness.
   assign cmp_gt = force_bad ? 1'b1 : (target > guess);
   assign cmp_lt = force_bad ? 1'b1 : (target < guess);
   assign cmp_eq = force_bad ? 1'b0 : (target == guess);

   sar_search #(.WIDTH(4)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .cmp_gt (cmp_gt),
      .cmp_lt (cmp_lt),
      .cmp_eq (cmp_eq),
      .guess  (guess),
      .busy   (busy),
      .done   (done),
      .result (result),
      .err    (err)
   );

   typedef struct {
      logic [3:0]  target;
      logic [15:0] gs;      // expected guesses, first test in the top nibble
      logic [3:0]  res;
      int          lat_on;  // done cycle with early exit enabled
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int  lat_exp;
      bit  seen;
      logic [15:0] gs;
`ifdef SAR_EARLY_EXIT_EN
      lat_exp = v.lat_on;
`else
      lat_exp = 5;
`endif
      gs = v.gs;
      seen = 1'b0;
      @(negedge clk);
      target = v.target;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 20 && !seen; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            check($sformatf("latency t=%0h", v.target), n, lat_exp);
            check($sformatf("result t=%0h", v.target), result, v.res);
            check($sformatf("err t=%0h", v.target), err, 1'b0);
            check($sformatf("busy_in_done t=%0h", v.target), busy, 1'b0);
         end else begin
            check($sformatf("busy t=%0h c=%0d", v.target, n), busy, 1'b1);
            if (n <= 4)
               check($sformatf("guess t=%0h c=%0d", v.target, n), guess, gs[15-4*(n-1) -: 4]);
            if (n == 1)
               check($sformatf("err_cleared t=%0h", v.target), err, 1'b0);
         end
      end
      if (!seen) check($sformatf("timeout t=%0h", v.target), 0, 1);
   endtask

   initial begin
      int  dones;
      int  done_cycle;
      bit  dropped;

      vecs[0] = '{target: 4'h8, gs: 16'h8CA9, res: 4'h8, lat_on: 2};
      vecs[1] = '{target: 4'h0, gs: 16'h8421, res: 4'h0, lat_on: 5};
      vecs[2] = '{target: 4'h5, gs: 16'h8465, res: 4'h5, lat_on: 5};
      vecs[3] = '{target: 4'hF, gs: 16'h8CEF, res: 4'hF, lat_on: 5};
      vecs[4] = '{target: 4'h3, gs: 16'h8423, res: 4'h3, lat_on: 5};
      vecs[5] = '{target: 4'hA, gs: 16'h8CAB, res: 4'hA, lat_on: 4};
      vecs[6] = '{target: 4'h1, gs: 16'h8421, res: 4'h1, lat_on: 5};

      repeat (2) @(negedge clk);
      check("reset busy", busy, 1'b0);
      check("reset done", done, 1'b0);
      check("reset guess", guess, 4'h0);
      check("reset result", result, 4'h0);
      check("reset err", err, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // guess holds its last trial value once the search is over
      @(negedge clk);
      check("guess_hold", guess, 4'h1);

      // Non-one-hot flags during the second test
      target = 4'h5;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 force_bad = 1'b1;
      @(posedge clk);
      #1 force_bad = 1'b0;
      @(negedge clk);
      check("err_case done", done, 1'b1);
      check("err_case err", err, 1'b1);
      check("err_case result", result, 4'h0);
      @(negedge clk);
      check("err_hold", err, 1'b1);
      check("err_idle done", done, 1'b0);
      run_vec(vecs[2]);

      // Reset in the middle of a search
      target = 4'h5;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst busy", busy, 1'b0);
      check("midrst done", done, 1'b0);
      check("midrst guess", guess, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (done) dones++;
      end
      check("midrst no_done", dones, 0);

      // start held through busy and DONE: one search only
      target = 4'h0;
      dones = 0;
      done_cycle = 0;
      dropped = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            if (done_cycle == 0) done_cycle = n;
            @(posedge clk);
            #1 start = 1'b0;
            dropped = 1'b1;
         end
      end
      if (!dropped) start = 1'b0;
      check("held_start done_count", dones, 1);
      check("held_start done_cycle", done_cycle, 5);
      check("held_start idle", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
